// File: rtl/print_pkg.sv
// Shared definitions for the print sweep scheduler: state encoding,
// parameter defaults and a small state-classification helper.
package print_pkg;

  localparam int HEIGHT_DEF     = 140;
  localparam int MAX_PASSES_DEF = 255;
  localparam int CNT_W_DEF      = 15;

  // ST_ABORT is the abort drain: no new requests, wait for the engine to empty.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_e;

  // States in which a job (or its abort drain) is still occupying the engine.
  function automatic logic is_busy_state(state_e s);
    case (s)
      ST_ISSUE, ST_DRAIN, ST_CHECK, ST_ABORT: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/print_sweep_scheduler.sv
// Print sweep scheduler: repeatedly sweeps rows 0..HEIGHT-1 through a row
// engine, accumulating removed cells, until a pass changes nothing or the
// pass limit is reached. All outputs come straight from registers.
module print_sweep_scheduler
  import print_pkg::*;
#(
  parameter int HEIGHT     = HEIGHT_DEF,
  parameter int MAX_PASSES = MAX_PASSES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             eng_valid,
  input  logic             eng_ready,
  output logic [7:0]       eng_row,
  input  logic             rsp_valid,
  input  logic [7:0]       rsp_count,
  input  logic             rsp_changed,
  output logic             busy,
  output logic [7:0]       pass_cnt,
  output logic             finished,
  output logic             timeout,
  output logic [CNT_W-1:0] result
);

  localparam int OUT_W = $clog2(HEIGHT + 1);
  localparam int SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;

  state_e           state_q, state_d;
  logic [7:0]       row_q, row_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [7:0]       pass_q, pass_d;
  logic             changed_q, changed_d;
  logic             timeout_q, timeout_d;
  logic             eng_valid_q, busy_q, finished_q;
  logic             acc_s, take_s, count_s;
  logic [SUM_W-1:0] sum_s;

  // Next-state, outstanding tracking and saturating accumulation.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    out_d     = out_q;
    result_d  = result_q;
    pass_d    = pass_q;
    changed_d = changed_q;
    timeout_d = timeout_q;

    acc_s   = eng_valid_q && eng_ready;
    // A response is only meaningful while something is outstanding in a live job.
    take_s  = rsp_valid && (out_q != {OUT_W{1'b0}}) &&
              (state_q inside {ST_ISSUE, ST_DRAIN, ST_CHECK, ST_ABORT});
    // During the abort drain responses retire but their counts are discarded.
    count_s = take_s && (state_q inside {ST_ISSUE, ST_DRAIN});
    sum_s   = SUM_W'(result_q) + SUM_W'(rsp_count);

    if (acc_s && !take_s) begin
      out_d = out_q + {{(OUT_W-1){1'b0}}, 1'b1};
    end else if (!acc_s && take_s) begin
      out_d = out_q - {{(OUT_W-1){1'b0}}, 1'b1};
    end else begin
      out_d = out_q;
    end

    if (count_s) begin
      if (sum_s > SUM_W'({CNT_W{1'b1}})) begin
        result_d = {CNT_W{1'b1}};
      end else begin
        result_d = sum_s[CNT_W-1:0];
      end
      changed_d = changed_q | rsp_changed;
    end else begin
      result_d  = result_q;
      changed_d = changed_q;
    end

    if (acc_s) begin
      row_d = row_q + 8'd1;
    end else begin
      row_d = row_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          row_d     = 8'd0;
          out_d     = {OUT_W{1'b0}};
          result_d  = {CNT_W{1'b0}};
          pass_d    = 8'd0;
          changed_d = 1'b0;
          timeout_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else if (acc_s && (row_q == 8'(HEIGHT - 1))) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else if (out_d == {OUT_W{1'b0}}) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CHECK: begin
        pass_d = pass_q + 8'd1;
        if (!changed_q) begin
          state_d = ST_DONE;
        end else if (({1'b0, pass_q} + 9'd1) == 9'(MAX_PASSES)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d   = ST_ISSUE;
          row_d     = 8'd0;
          changed_d = 1'b0;
        end
      end
      ST_ABORT: begin
        if (out_d == {OUT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ABORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= 8'd0;
      out_q       <= {OUT_W{1'b0}};
      result_q    <= {CNT_W{1'b0}};
      pass_q      <= 8'd0;
      changed_q   <= 1'b0;
      timeout_q   <= 1'b0;
      eng_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      out_q       <= out_d;
      result_q    <= result_d;
      pass_q      <= pass_d;
      changed_q   <= changed_d;
      timeout_q   <= timeout_d;
      eng_valid_q <= (state_d == ST_ISSUE);
      busy_q      <= is_busy_state(state_d);
      finished_q  <= (state_d == ST_DONE);
    end
  end

  assign eng_valid = eng_valid_q;
  assign eng_row   = row_q;
  assign busy      = busy_q;
  assign pass_cnt  = pass_q;
  assign finished  = finished_q;
  assign timeout   = timeout_q;
  assign result    = result_q;

endmodule

// File: tb/tb_print_sweep_scheduler.sv
// Self-checking bench for print_sweep_scheduler: a behavioural two-cycle row
// engine driven from the main sequence, and a scoreboard of expected job results.
module tb_print_sweep_scheduler;

  localparam int H  = 4;
  localparam int MP = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          eng_ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic [7:0]    rsp_count = 8'd0;
  logic          rsp_changed = 1'b0;
  logic          eng_valid;
  logic [7:0]    eng_row;
  logic          busy;
  logic [7:0]    pass_cnt;
  logic          finished;
  logic          timeout;
  logic [CW-1:0] result;

  print_sweep_scheduler #(.HEIGHT(H), .MAX_PASSES(MP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_row(eng_row),
    .rsp_valid(rsp_valid), .rsp_count(rsp_count), .rsp_changed(rsp_changed),
    .busy(busy), .pass_cnt(pass_cnt), .finished(finished), .timeout(timeout),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct { int res; int pc; int to; } exp_t;
  typedef struct { int due; int cnt; bit chg; } pend_t;

  exp_t   sb[$];
  pend_t  eq[$];
  int     cnt_tab[3][4];
  bit     chg_tab[3][4];
  int     ready_mode = 0;
  int     cyc = 0;
  int     acc_total = 0;
  int     job_base = 0;
  int     total = 0;
  int     passed = 0;
  bit     prev_v = 1'b0;
  bit     prev_acc = 1'b0;
  logic [7:0] prev_row = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_pass(input int p, input int c0, input int c1, input int c2, input int c3,
                          input bit g0, input bit g1, input bit g2, input bit g3);
    cnt_tab[p][0] = c0; cnt_tab[p][1] = c1; cnt_tab[p][2] = c2; cnt_tab[p][3] = c3;
    chg_tab[p][0] = g0; chg_tab[p][1] = g1; chg_tab[p][2] = g2; chg_tab[p][3] = g3;
  endtask

  // One clock of the engine model: respond at the falling edge, then decide the
  // upcoming accept and record what the engine will answer two cycles later.
  task automatic tick();
    int p;
    int r;
    int acc_in_job;
    pend_t e;
    @(negedge clk);
    cyc++;
    if (eq.size() > 0 && eq[0].due <= cyc) begin
      e = eq.pop_front();
      rsp_valid = 1'b1;
      rsp_count = 8'(e.cnt);
      rsp_changed = e.chg;
    end else begin
      rsp_valid = 1'b0;
      rsp_count = 8'd0;
      rsp_changed = 1'b0;
    end
    case (ready_mode)
      0:       eng_ready = 1'b1;
      1:       eng_ready = ((cyc % 2) == 0);
      default: eng_ready = 1'b0;
    endcase
    #3;
    if (rst_n && eng_valid) begin
      if (prev_v && !prev_acc) check("row_stable", 32'(eng_row), 32'(prev_row));
      if (eng_ready) begin
        acc_in_job = acc_total - job_base;
        r = acc_in_job % H;
        p = acc_in_job / H;
        if (p > 2) p = 2;
        check("row_order", 32'(eng_row), 32'(r));
        e.due = cyc + 2;
        e.cnt = cnt_tab[p][r];
        e.chg = chg_tab[p][r];
        eq.push_back(e);
        acc_total++;
      end
    end
    prev_v   = rst_n && eng_valid;
    prev_acc = rst_n && eng_valid && eng_ready;
    prev_row = eng_row;
  endtask

  task automatic do_start(input int res, input int pc, input int to);
    exp_t x;
    x.res = res; x.pc = pc; x.to = to;
    sb.push_back(x);
    job_base = acc_total;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t x;
    for (int i = 0; i < 400 && !finished; i++) tick();
    check({tag, "_finished"}, 32'(finished), 32'd1);
    x = sb.pop_front();
    check({tag, "_result"}, 32'(result), 32'(x.res));
    check({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(x.pc));
    check({tag, "_timeout"}, 32'(timeout), 32'(x.to));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_eng_valid"}, 32'(eng_valid), 32'd0);
    check({tag, "_eng_row"}, 32'(eng_row), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_finished"}, 32'(finished), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_pass_cnt"}, 32'(pass_cnt), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
  endtask

  initial begin
    for (int p = 0; p < 3; p++) set_pass(p, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Two passes: first removes {1,0,2,0} and changes, second is quiet.
    ready_mode = 0;
    set_pass(0, 1, 0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    set_pass(1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_pass(2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start(3, 2, 0);
    wait_done("basic");
    tick();
    tick();
    check("basic_hold_result", 32'(result), 32'd3);
    check("basic_hold_finished", 32'(finished), 32'd1);

    // Always changing with a stalling engine: ends on the pass limit.
    ready_mode = 1;
    for (int p = 0; p < 3; p++) set_pass(p, 1, 1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    do_start(12, 3, 1);
    check("restart_clears_finished", 32'(finished), 32'd0);
    wait_done("limit");

    // Saturation: 5+5+5+5 = 20 clamps to 15.
    ready_mode = 0;
    set_pass(0, 5, 5, 5, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start(15, 1, 0);
    wait_done("saturate");

    // Wide count 200 still saturates a 4-bit result.
    set_pass(0, 0, 200, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start(15, 1, 0);
    wait_done("sat_wide");

    // Abort with two requests outstanding.
    for (int p = 0; p < 3; p++) set_pass(p, 1, 1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    do_start(0, 0, 0);
    void'(sb.pop_back());
    for (int i = 0; i < 20 && eq.size() < 2; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid_drop", 32'(eng_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20 && busy; i++) tick();
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_drained", 32'(eq.size()), 32'd0);
    check("abort_finished", 32'(finished), 32'd0);
    tick();
    check("abort_no_issue", 32'(eng_valid), 32'd0);

    // Reset in the middle of the drain phase.
    set_pass(0, 2, 2, 2, 2, 1'b1, 1'b1, 1'b1, 1'b1);
    job_base = acc_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && (acc_total - job_base) < H; i++) tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("late_rsp_result", 32'(result), 32'd0);
    check("late_rsp_busy", 32'(busy), 32'd0);
    set_pass(0, 0, 3, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start(4, 1, 0);
    wait_done("fresh");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/print_sweep_scheduler.md
PRINT_SWEEP_SCHEDULER -- requirements
Module: print_sweep_scheduler

Interface
REQ-001 SHALL have parameter HEIGHT, default 140, meaning grid rows swept per pass.
REQ-002 SHALL have parameter MAX_PASSES, default 255, meaning pass limit before timeout.
REQ-003 SHALL have parameter CNT_W, default 15, meaning result/accumulator width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  begin job; sampled only in IDLE or DONE.
REQ-007 SHALL have port abort  input  1  cancel running job.
REQ-008 SHALL have port eng_valid  output  1  row request to row engine.
REQ-009 SHALL have port eng_ready  input  1  engine accepts request this cycle.
REQ-010 SHALL have port eng_row  output  8  row index of request.
REQ-011 SHALL have port rsp_valid  input  1  engine result for oldest outstanding row.
REQ-012 SHALL have port rsp_count  input  8  cells removed in that row.
REQ-013 SHALL have port rsp_changed  input  1  row contents changed.
REQ-014 SHALL have port busy  output  1  job in progress.
REQ-015 SHALL have port pass_cnt  output  8  completed passes of current/last job.
REQ-016 SHALL have port finished  output  1  job done, held until next start.
REQ-017 SHALL have port timeout  output  1  job ended by MAX_PASSES, held with finished.
REQ-018 SHALL have port result  output  CNT_W  total cells removed over all passes.

Function
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN, CHECK, DONE.
REQ-020 SHALL go IDLE/DONE->ISSUE on start, clearing result, pass_cnt, finished, timeout, row pointer, outstanding counter, changed flag.
REQ-021 SHALL in ISSUE assert eng_valid with eng_row = row pointer, incrementing pointer only on eng_valid&&eng_ready; eng_row stable while stalled.
REQ-022 SHALL move ISSUE->DRAIN in the cycle row HEIGHT-1 is accepted; eng_valid low outside ISSUE.
REQ-023 SHALL track outstanding = accepted - responded; simultaneous accept and response leaves it unchanged.
REQ-024 SHALL on each rsp_valid add rsp_count (zero-extended) to result and OR rsp_changed into the pass changed flag; responses accepted in ISSUE and DRAIN.
REQ-025 SHALL move DRAIN->CHECK when outstanding reaches zero after HEIGHT responses of the pass.
REQ-026 SHALL in CHECK (one cycle) increment pass_cnt; if changed flag clear -> DONE; else if pass_cnt+1 == MAX_PASSES -> DONE with timeout=1; else -> ISSUE with row pointer and changed flag cleared.
REQ-027 SHALL in DONE assert finished=1, busy=0, hold result/pass_cnt/timeout until next start.
REQ-028 SHALL saturate result at 2^CNT_W-1 rather than wrap.
REQ-029 SHALL on abort in ISSUE/DRAIN stop issuing immediately, wait for outstanding to reach zero (discarding counts), then return to IDLE with finished=0; abort ignored in IDLE, CHECK, DONE.
REQ-030 SHALL ignore rsp_valid in IDLE and DONE.
REQ-031 SHALL assert busy in ISSUE, DRAIN, CHECK and during abort drain.
REQ-032 SHALL have zero-cycle latency from state entry to eng_valid (registered outputs, no combinational path rsp_*->eng_valid).

Reset
REQ-033 SHALL on rst_n low asynchronously force IDLE, eng_valid=0, eng_row=0, busy=0, finished=0, timeout=0, pass_cnt=0, result=0, outstanding=0.
REQ-034 SHALL treat reset mid-job as full abandonment; outstanding engine responses after release are ignored in IDLE.

Structure
REQ-035 SHALL place state encoding and HEIGHT/CNT_W defaults in shared package print_pkg.
REQ-036 SHALL be a single module with no sub-modules; outstanding counter sized for HEIGHT.

Verification
REQ-037 SHALL cover: HEIGHT=4, eng_ready=1, 2-cycle engine, pass1 counts {1,0,2,0} changed, pass2 all 0 unchanged -> result=3, pass_cnt=2, finished=1, timeout=0.
REQ-038 SHALL cover: eng_ready toggled 1/0 every cycle -> each eng_row 0..HEIGHT-1 issued exactly once per pass, eng_row stable during stall.
REQ-039 SHALL cover: rsp_changed always 1, MAX_PASSES=3 -> finished=1, timeout=1, pass_cnt=3.
REQ-040 SHALL cover: CNT_W=4, counts summing 20 -> result=15 saturated.
REQ-041 SHALL cover: abort with 2 outstanding -> eng_valid drops next cycle, busy until 2 responses, then IDLE, finished=0.
REQ-042 SHALL cover: rst_n pulsed low mid-DRAIN -> all outputs zero immediately; late rsp_valid ignored; new start yields correct fresh result.
